// File: rtl/mem_writeback.sv
// mem_writeback: retires execute bundles. It drives register-file and CSR writeback and the PC redirect,
// and runs loads/stores over a req/ack data port. Define MEM_TIMEOUT_EN to bound the memory wait.
module mem_writeback #(
  parameter int N_param     = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [63:0]        Single_Instruction_i,
  input  logic [4:0]         rd_i,
  input  logic [11:0]        csr_i,
  input  logic [N_param-1:0] alu_result_1,
  input  logic [N_param-1:0] alu_result_2,
  input  logic [N_param-1:0] operand2_pi,
  input  logic               write_reg_file_wire,
  input  logic               write_csr_wire,
  input  logic               branch_inst_wire,
  input  logic               jump_inst_wire,
  output logic               o_mem_req,
  output logic               o_mem_we,
  output logic [N_param-1:0] o_mem_addr,
  output logic [N_param-1:0] o_mem_wdata,
  output logic [3:0]         o_mem_wstrb,
  input  logic               i_mem_ack,
  input  logic [N_param-1:0] i_mem_rdata,
  output logic               o_rf_we,
  output logic [4:0]         o_rf_waddr,
  output logic [N_param-1:0] o_rf_wdata,
  output logic               o_csr_we,
  output logic [11:0]        o_csr_addr,
  output logic [N_param-1:0] o_csr_wdata,
  output logic               o_redirect,
  output logic [N_param-1:0] o_redirect_pc,
  output logic               o_misaligned,
  output logic               o_mem_fault
);

  if (N_param != 32 || MEM_TIMEOUT < 1) begin : g_param_check
    $error("mem_writeback: only N_param=32 and MEM_TIMEOUT>=1 are supported");
  end

  // Bit positions in the shared one-hot instruction code (RV32I order, then the six CSR ops).
  localparam int INST_JALR = 3;
  localparam int INST_LB   = 10;
  localparam int INST_LH   = 11;
  localparam int INST_LW   = 12;
  localparam int INST_LBU  = 13;
  localparam int INST_LHU  = 14;
  localparam int INST_SB   = 15;
  localparam int INST_SH   = 16;
  localparam int INST_SW   = 17;
  localparam logic [63:0] KNOWN_MASK = 64'h0000_07FF_FFFF_FFFF;

  typedef enum logic [1:0] {S_IDLE, S_MEM, S_WB} state_e;
  typedef enum logic [2:0] {SZ_B, SZ_BU, SZ_H, SZ_HU, SZ_W} size_e;

  state_e             state_q, state_d;
  logic               mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [N_param-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [3:0]         mem_wstrb_q, mem_wstrb_d;
  size_e              size_q, size_d;
  logic [1:0]         lane_q, lane_d;
  logic [4:0]         rd_q, rd_d;
  logic               rf_we_q, rf_we_d;
  logic [4:0]         rf_waddr_q, rf_waddr_d;
  logic [N_param-1:0] rf_wdata_q, rf_wdata_d;
  logic               csr_we_q, csr_we_d;
  logic [11:0]        csr_addr_q, csr_addr_d;
  logic [N_param-1:0] csr_wdata_q, csr_wdata_d;
  logic               redirect_q, redirect_d;
  logic [N_param-1:0] redirect_pc_q, redirect_pc_d;
  logic               misaligned_q, misaligned_d;
`ifdef MEM_TIMEOUT_EN
  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  logic [TW-1:0] cnt_q, cnt_d;
  logic          mem_fault_q, mem_fault_d;
  assign o_mem_fault = mem_fault_q;
`else
  assign o_mem_fault = 1'b0;
`endif

  logic accept, known, is_load, is_store, misaligned;
  logic is_sb, is_sh, is_sw;
  logic [1:0]         lane;
  size_e              ld_size;
  logic [N_param-1:0] st_wdata;
  logic [3:0]         st_wstrb;

  assign o_ready  = (state_q == S_IDLE);
  assign accept   = i_valid & o_ready;
  // Zero, multi-hot or unlisted codes are accepted but retire with no side effects.
  assign known    = $onehot(Single_Instruction_i) && |(Single_Instruction_i & KNOWN_MASK);
  assign is_sb    = Single_Instruction_i[INST_SB];
  assign is_sh    = Single_Instruction_i[INST_SH];
  assign is_sw    = Single_Instruction_i[INST_SW];
  assign is_store = is_sb | is_sh | is_sw;
  assign is_load  = Single_Instruction_i[INST_LB]  | Single_Instruction_i[INST_LH]
                  | Single_Instruction_i[INST_LW]  | Single_Instruction_i[INST_LBU]
                  | Single_Instruction_i[INST_LHU];
  assign lane     = alu_result_1[1:0];
  assign misaligned =
      ((Single_Instruction_i[INST_LH] | Single_Instruction_i[INST_LHU] | is_sh) & lane[0])
    | ((Single_Instruction_i[INST_LW] | is_sw) & (|lane));

  // NOTE: every signal assigned in an always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    ld_size  = SZ_W;
    st_wdata = '0;
    st_wstrb = 4'b0000;
    if      (Single_Instruction_i[INST_LB])  ld_size = SZ_B;
    else if (Single_Instruction_i[INST_LBU]) ld_size = SZ_BU;
    else if (Single_Instruction_i[INST_LH])  ld_size = SZ_H;
    else if (Single_Instruction_i[INST_LHU]) ld_size = SZ_HU;
    if (is_sb) begin
      st_wdata = {4{operand2_pi[7:0]}};
      st_wstrb = 4'b0001 << lane;
    end else if (is_sh) begin
      st_wdata = {2{operand2_pi[15:0]}};
      st_wstrb = lane[1] ? 4'b1100 : 4'b0011;
    end else if (is_sw) begin
      st_wdata = operand2_pi;
      st_wstrb = 4'b1111;
    end
  end

  function automatic logic [31:0] fmt_load(size_e sz, logic [1:0] ln, logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{ln, 3'b000} +: 8];
    h = ln[1] ? w[31:16] : w[15:0];
    case (sz)
      SZ_B:    r = {{24{b[7]}}, b};
      SZ_BU:   r = {24'd0, b};
      SZ_H:    r = {{16{h[15]}}, h};
      SZ_HU:   r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_wstrb_d   = mem_wstrb_q;
    size_d        = size_q;
    lane_d        = lane_q;
    rd_d          = rd_q;
    rf_we_d       = 1'b0;
    rf_waddr_d    = rf_waddr_q;
    rf_wdata_d    = rf_wdata_q;
    csr_we_d      = 1'b0;
    csr_addr_d    = csr_addr_q;
    csr_wdata_d   = csr_wdata_q;
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;
    misaligned_d  = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d         = cnt_q;
    mem_fault_d   = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (accept && known) begin
          if (is_load || is_store) begin
            if (misaligned) begin
              misaligned_d = 1'b1;
            end else begin
              state_d     = S_MEM;
              mem_req_d   = 1'b1;
              mem_we_d    = is_store;
              mem_addr_d  = {alu_result_1[N_param-1:2], 2'b00};
              mem_wdata_d = st_wdata;
              mem_wstrb_d = st_wstrb;
              size_d      = ld_size;
              lane_d      = lane;
              rd_d        = rd_i;
`ifdef MEM_TIMEOUT_EN
              cnt_d       = '0;
`endif
            end
          end else begin
            if (write_reg_file_wire && rd_i != 5'd0) begin
              rf_we_d    = 1'b1;
              rf_waddr_d = rd_i;
              rf_wdata_d = alu_result_1;
            end
            if (write_csr_wire) begin
              csr_we_d    = 1'b1;
              csr_addr_d  = csr_i;
              csr_wdata_d = alu_result_2;
            end
            if (branch_inst_wire || jump_inst_wire) begin
              redirect_d    = 1'b1;
              redirect_pc_d = Single_Instruction_i[INST_JALR] ? {alu_result_2[N_param-1:1], 1'b0}
                                                               : alu_result_2;
            end
          end
        end
      end
      S_MEM: begin
        // Load data is formatted straight off the ack so the write lands in the WB cycle.
        if (i_mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = S_WB;
          if (!mem_we_q && rd_q != 5'd0) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = rd_q;
            rf_wdata_d = fmt_load(size_q, lane_q, i_mem_rdata);
          end
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_q == TW'(MEM_TIMEOUT - 1)) begin
          mem_req_d   = 1'b0;
          mem_fault_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking <= so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= S_IDLE;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_wstrb_q   <= 4'b0000;
      size_q        <= SZ_W;
      lane_q        <= 2'b00;
      rd_q          <= 5'd0;
      rf_we_q       <= 1'b0;
      rf_waddr_q    <= 5'd0;
      rf_wdata_q    <= '0;
      csr_we_q      <= 1'b0;
      csr_addr_q    <= 12'd0;
      csr_wdata_q   <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      misaligned_q  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q         <= '0;
      mem_fault_q   <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_wstrb_q   <= mem_wstrb_d;
      size_q        <= size_d;
      lane_q        <= lane_d;
      rd_q          <= rd_d;
      rf_we_q       <= rf_we_d;
      rf_waddr_q    <= rf_waddr_d;
      rf_wdata_q    <= rf_wdata_d;
      csr_we_q      <= csr_we_d;
      csr_addr_q    <= csr_addr_d;
      csr_wdata_q   <= csr_wdata_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      misaligned_q  <= misaligned_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q         <= cnt_d;
      mem_fault_q   <= mem_fault_d;
`endif
    end
  end

  assign o_mem_req     = mem_req_q;
  assign o_mem_we      = mem_we_q;
  assign o_mem_addr    = mem_addr_q;
  assign o_mem_wdata   = mem_wdata_q;
  assign o_mem_wstrb   = mem_wstrb_q;
  assign o_rf_we       = rf_we_q;
  assign o_rf_waddr    = rf_waddr_q;
  assign o_rf_wdata    = rf_wdata_q;
  assign o_csr_we      = csr_we_q;
  assign o_csr_addr    = csr_addr_q;
  assign o_csr_wdata   = csr_wdata_q;
  assign o_redirect    = redirect_q;
  assign o_redirect_pc = redirect_pc_q;
  assign o_misaligned  = misaligned_q;

endmodule

// File: doc/mem_writeback.md
Name: mem_writeback

Overview:
Back end of the execute interface: consumes the execute stage's result bundle (one-hot instruction, rd, alu_result_1/2, write/branch/jump/csr flags) and retires it. Performs loads/stores through a request/acknowledge data-memory port with byte-lane formatting. Drives the register-file write port, the CSR write port and the PC redirect. Sits between execute and the register file/fetch in the riscv32i core.

Parameters:
N_param, 32, datapath width (only 32 supported)
MEM_TIMEOUT, 15, max wait cycles for i_mem_ack (used only with MEM_TIMEOUT_EN)

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  asynchronous active-high reset
i_valid  in  1  execute bundle valid
o_ready  out  1  block can accept a bundle this cycle
Single_Instruction_i  in  64  one-hot instruction code, shared `inst_* encodings
rd_i  in  5  destination register
csr_i  in  12  CSR address
alu_result_1  in  32  primary result (load/store address, rd data, branch-taken bit)
alu_result_2  in  32  secondary result (branch/jump target, CSR write data)
operand2_pi  in  32  store data (rs2)
write_reg_file_wire  in  1  rd write request
write_csr_wire  in  1  CSR write request
branch_inst_wire  in  1  taken branch
jump_inst_wire  in  1  JAL/JALR
o_mem_req  out  1  memory request, held until ack
o_mem_we  out  1  1=store
o_mem_addr  out  32  word-aligned address ({alu_result_1[31:2],2'b00})
o_mem_wdata  out  32  lane-positioned store data
o_mem_wstrb  out  4  byte enables
i_mem_ack  in  1  one-cycle completion
i_mem_rdata  in  32  read word, valid with ack
o_rf_we, o_rf_waddr, o_rf_wdata  out  1/5/32  register-file write
o_csr_we, o_csr_addr, o_csr_wdata  out  1/12/32  CSR write
o_redirect, o_redirect_pc  out  1/32  PC redirect
o_misaligned  out  1  misaligned access pulse
o_mem_fault  out  1  memory timeout pulse

Behaviour:
- Reset: all outputs 0, o_ready=1 after release; state IDLE; captured bundle cleared.
- Accept = i_valid & o_ready; o_ready = (state==IDLE).
- States: IDLE, MEM, WB.
- IDLE, accepted non-memory op: next cycle one-cycle pulse of o_rf_we (if write_reg_file_wire & rd_i!=0, wdata=alu_result_1), o_csr_we (if write_csr_wire, wdata=alu_result_2, addr=csr_i), o_redirect (if branch or jump). State stays IDLE -> one op/cycle throughput.
- Redirect target = alu_result_2 with bit0 cleared for JALR, else alu_result_2 unchanged.
- IDLE, accepted load/store, aligned: -> MEM; o_mem_req=1 from the next cycle until i_mem_ack seen (inclusive), address/data/strobe stable throughout.
- MEM, i_mem_ack: capture rdata, drop req next cycle, -> WB. WB: loads pulse o_rf_we with formatted data (if rd_i!=0); stores write nothing; -> IDLE. Load latency = ack cycle + 1.
- Alignment: LH/LHU/SH need addr[0]=0; LW/SW need addr[1:0]=0. Misaligned: no request, o_misaligned one-cycle pulse next cycle, no rf write, stay IDLE.
- Load format by lane addr[1:0]: LB/LBU sign/zero-extend byte; LH/LHU sign/zero-extend halfword at addr[1].
- Store: SB wstrb=0001<<addr[1:0], data byte replicated on all lanes; SH wstrb=0011 or 1100, halfword replicated; SW wstrb=1111.
- i_mem_ack outside MEM ignored.
- Unknown/zero one-hot: accepted, no side effects.
- Async reset mid-MEM: req drops immediately, no writeback, IDLE.

Optional Feature:
MEM_TIMEOUT_EN: defined -> counter cleared on entry to MEM, increments each MEM cycle without ack; on reaching MEM_TIMEOUT, drop req, pulse o_mem_fault one cycle, no rf write, -> IDLE. Ack on the timeout cycle wins (normal completion). Undefined -> waits indefinitely; o_mem_fault tied 0.

Test Plan:
- ADD, rd=5, alu_result_1=0x0000_0007 -> next cycle o_rf_we=1, waddr=5, wdata=0x7; rd=0 variant -> o_rf_we=0.
- LB addr 0x103, memory returns 0x80AA_BBCC after 3-cycle ack delay -> req held 3 cycles, wdata=0xFFFF_FF80; LBU same -> 0x0000_0080.
- SH addr 0x202, operand2_pi=0x1234_ABCD -> o_mem_addr=0x200, wstrb=1100, wdata=0xABCD_ABCD, no rf write.
- LW addr 0x106 -> o_misaligned pulse, o_mem_req never asserted, o_ready stays 1.
- JALR alu_result_1=0x44, alu_result_2=0x1001, rd=1 -> o_redirect=1, redirect_pc=0x1000, rf x1=0x44; taken BEQ target 0x80 -> redirect 0x80, no rf write.
- Reset asserted during MEM wait -> req low same cycle, no writeback; with MEM_TIMEOUT_EN, no ack for 15 cycles -> o_mem_fault pulse, back to IDLE.
